// File: rtl/spi_exe_unit_n_if.sv
// SPI pin bundle for spi_exe_unit_n: chip select, serial data, done/abort strobes.
// The slave modport is the execution unit's side; master is the SPI host's side.
interface spi_exe_unit_n_if;
  logic i_cs;
  logic i_mosi;
  logic o_miso;
  logic o_done;
  logic o_abort;

  modport slave  (input  i_cs, i_mosi, output o_miso, o_done, o_abort);
  modport master (output i_cs, i_mosi, input  o_miso, o_done, o_abort);
endinterface

// File: rtl/spi_exe_unit_n.sv
// SPI-slave ALU: shifts in A, B, opcode; returns {result, flags} in the same CS frame.
// Optional SPI_EXE_PARITY_EN appends an even-parity bit after the flags.
module spi_exe_unit_n #(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  spi_exe_unit_n_if.slave   bus
);

`ifdef SPI_EXE_PARITY_EN
  localparam int OUTW = W + 5;
`else
  localparam int OUTW = W + 4;
`endif
  localparam int CW = $clog2(OUTW + 1);

  localparam logic [CW-1:0] A_END  = CW'(W - 1);
  localparam logic [CW-1:0] OP_END = CW'(OPW - 1);
  localparam logic [CW-1:0] S_END  = CW'(OUTW - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_OP, COMPUTE, SEND, WAIT_CS
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [OPW-1:0]  op_q;
  logic [OUTW-1:0] out_q;
  logic            done_q;
  logic            abort_q;

  logic [W:0]      sum;
  logic [W-1:0]    res;
  logic            cf;
  logic            vf;
  logic            zf_en;
  logic [3:0]      flags;
  logic [OUTW-1:0] out_d;

  always_comb begin
    sum   = '0;
    res   = '0;
    cf    = 1'b0;
    vf    = 1'b0;
    zf_en = 1'b1;
    case (op_q)
      4'd0: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        res = sum[W-1:0];
        cf  = sum[W];
        vf  = (a_q[W-1] == b_q[W-1]) && (res[W-1] != a_q[W-1]);
      end
      4'd1: begin
        res = a_q - b_q;
        cf  = (a_q < b_q);
        vf  = (a_q[W-1] != b_q[W-1]) && (res[W-1] != a_q[W-1]);
      end
      4'd2: res = a_q & b_q;
      4'd3: res = a_q | b_q;
      4'd4: res = a_q ^ b_q;
      4'd5: res = ~a_q;
      4'd6: begin
        res = {a_q[W-2:0], 1'b0};
        cf  = a_q[W-1];
      end
      4'd7: begin
        res = {1'b0, a_q[W-1:1]};
        cf  = a_q[0];
      end
      // Reserved opcodes report nothing, not even a zero result.
      default: zf_en = 1'b0;
    endcase
    flags = {vf, zf_en && (res == '0), res[W-1], cf};
`ifdef SPI_EXE_PARITY_EN
    out_d = {res, flags, ^{res, flags}};
`else
    out_d = {res, flags};
`endif
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (state_q != IDLE && state_q != WAIT_CS && bus.i_cs) begin
        abort_q <= 1'b1;
        cnt_q   <= '0;
        out_q   <= '0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (!bus.i_cs) begin
              a_q     <= {{(W-1){1'b0}}, bus.i_mosi};
              cnt_q   <= CW'(1);
              state_q <= LOAD_A;
            end
          end
          LOAD_A: begin
            a_q <= {a_q[W-2:0], bus.i_mosi};
            if (cnt_q == A_END) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          LOAD_B: begin
            b_q <= {b_q[W-2:0], bus.i_mosi};
            if (cnt_q == A_END) begin
              cnt_q   <= '0;
              state_q <= LOAD_OP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          LOAD_OP: begin
            op_q <= {op_q[OPW-2:0], bus.i_mosi};
            if (cnt_q == OP_END) begin
              cnt_q   <= '0;
              state_q <= COMPUTE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          COMPUTE: begin
            out_q   <= out_d;
            cnt_q   <= '0;
            state_q <= SEND;
          end
          SEND: begin
            out_q <= out_q << 1;
            if (cnt_q == S_END) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= WAIT_CS;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAIT_CS: begin
            if (bus.i_cs) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_miso  = (state_q == SEND) ? out_q[OUTW-1] : 1'b0;
  assign bus.o_done  = done_q;
  assign bus.o_abort = abort_q;

endmodule

// File: tb/tb_spi_exe_unit_n.sv
// Bench for spi_exe_unit_n: W=8 and W=16 instances, scoreboard of expected MISO words.
module tb_spi_exe_unit_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] exp_q[$];

`ifdef SPI_EXE_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  always #5 clk = ~clk;

  spi_exe_unit_n_if b8();
  spi_exe_unit_n_if b16();

  spi_exe_unit_n #(.W(8),  .OPW(4)) dut8  (.i_sclk(clk), .i_rst(rst), .bus(b8));
  spi_exe_unit_n #(.W(16), .OPW(4)) dut16 (.i_sclk(clk), .i_rst(rst), .bus(b16));

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [36:0] exp;
  } vec_t;

  function automatic logic [36:0] with_par(logic [36:0] x);
`ifdef SPI_EXE_PARITY_EN
    return (x << 1) | {36'd0, ^x};
`else
    return x;
`endif
  endfunction

  function automatic logic [36:0] model(int w, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [32:0] full;
    logic [31:0] mask, r;
    logic cf, vf, zf;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = 0; cf = 0; vf = 0;
    case (op)
      4'd0: begin
        full = {1'b0, a} + {1'b0, b};
        r = full[31:0] & mask; cf = full[w];
        vf = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd1: begin
        r = (a - b) & mask; cf = (a < b);
        vf = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a & mask;
      4'd6: begin r = (a << 1) & mask; cf = a[w-1]; end
      4'd7: begin r = a >> 1; cf = a[0]; end
      default: r = 0;
    endcase
    zf = (op < 4'd8) && (r == 0);
    return with_par(({5'd0, r} << 4) | {33'd0, vf, zf, r[w-1], cf});
  endfunction

  task automatic drive(int sel, logic cs, logic mosi);
    if (sel == 0) begin b8.i_cs = cs;  b8.i_mosi = mosi;  end
    else          begin b16.i_cs = cs; b16.i_mosi = mosi; end
  endtask

  function automatic logic miso(int sel);
    return (sel == 0) ? b8.o_miso : b16.o_miso;
  endfunction

  function automatic logic done(int sel);
    return (sel == 0) ? b8.o_done : b16.o_done;
  endfunction

  // Shifts A, B, OP in MSB first, then sets up the turnaround edge.
  task automatic send_fields(int sel, int w, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    for (int i = w - 1; i >= 0; i--) begin @(negedge clk); drive(sel, 1'b0, a[i]); end
    for (int i = w - 1; i >= 0; i--) begin @(negedge clk); drive(sel, 1'b0, b[i]); end
    for (int i = 3; i >= 0; i--)     begin @(negedge clk); drive(sel, 1'b0, op[i]); end
    @(negedge clk); drive(sel, 1'b0, 1'b0);
  endtask

  task automatic do_frame(int sel, int w, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                          int hold, output logic [36:0] got, output int early,
                          output logic done_end, output logic done_after, output int junk);
    got = 0; early = 0; junk = 0;
    send_fields(sel, w, a, b, op);
    for (int i = 0; i < w + 4 + PX; i++) begin
      @(negedge clk);
      got = {got[35:0], miso(sel)};
      if (done(sel)) early++;
    end
    @(negedge clk);
    done_end = done(sel);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (miso(sel) || done(sel)) junk++;
    end
    drive(sel, 1'b1, 1'b0);
    @(negedge clk);
    done_after = done(sel);
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b8.o_miso, b8.o_done, b8.o_abort} !== 3'b000) begin
      errors++; $display("FAIL reset_w8 got=%b exp=000", {b8.o_miso, b8.o_done, b8.o_abort});
    end
    checks++;
    if ({b16.o_miso, b16.o_done, b16.o_abort} !== 3'b000) begin
      errors++; $display("FAIL reset_w16 got=%b exp=000", {b16.o_miso, b16.o_done, b16.o_abort});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b8.o_miso, b8.o_done, b8.o_abort} !== 3'b000) begin
      errors++; $display("FAIL idle_cs_high got=%b exp=000", {b8.o_miso, b8.o_done, b8.o_abort});
    end
  endtask

  task automatic test_alu_vectors();
    vec_t v[5];
    logic [36:0] got, e;
    int early, junk;
    logic de, da;
    v[0] = '{8,  32'h7F,   32'h01, 4'd0, with_par(37'h80A)};
    v[1] = '{8,  32'h00,   32'h01, 4'd1, with_par(37'hFF3)};
    v[2] = '{8,  32'hF0,   32'h0F, 4'd2, with_par(37'h004)};
    v[3] = '{8,  32'hF0,   32'h0F, 4'd9, with_par(37'h000)};
    v[4] = '{16, 32'hFFFF, 32'h01, 4'd0, with_par(37'h00005)};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(v[i].exp);
      do_frame((v[i].w == 16) ? 1 : 0, v[i].w, v[i].a, v[i].b, v[i].op, (i == 2) ? 3 : 0,
               got, early, de, da, junk);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL vec%0d_miso got=%h exp=%h", i, got, e); end
      checks++;
      if ({early != 0, de, da} !== 3'b010) begin
        errors++; $display("FAIL vec%0d_done early=%0d end=%b after=%b exp=0,1,0", i, early, de, da);
      end
      if (i == 2) begin
        checks++;
        if (junk !== 0) begin errors++; $display("FAIL wait_cs_quiet got=%0d exp=0", junk); end
      end
    end
`ifdef SPI_EXE_PARITY_EN
    checks++;
    if (with_par(37'h80A) !== 37'h1015) begin
      errors++; $display("FAIL parity_const got=%h exp=1015", with_par(37'h80A));
    end
`endif
  endtask

  task automatic test_abort();
    logic [36:0] got, e;
    int early, junk;
    logic de, da;
    for (int i = 7; i >= 0; i--) begin @(negedge clk); drive(0, 1'b0, 1'b1); end
    for (int i = 0; i < 3; i++)  begin @(negedge clk); drive(0, 1'b0, 1'b0); end
    @(negedge clk);
    checks++;
    if (b8.o_abort !== 1'b0) begin errors++; $display("FAIL abort_early got=%b exp=0", b8.o_abort); end
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({b8.o_abort, b8.o_miso} !== 2'b10) begin
      errors++; $display("FAIL abort_pulse got=%b exp=10", {b8.o_abort, b8.o_miso});
    end
    @(negedge clk);
    checks++;
    if (b8.o_abort !== 1'b0) begin errors++; $display("FAIL abort_width got=%b exp=0", b8.o_abort); end
    exp_q.push_back(with_par(37'h020));
    do_frame(0, 8, 32'h01, 32'h01, 4'd0, 0, got, early, de, da, junk);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL after_abort_miso got=%h exp=%h", got, e); end
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL after_abort_done got=%b exp=1", de); end
  endtask

  task automatic test_reset_mid_send();
    int dones = 0;
    send_fields(0, 8, 32'h7F, 32'h01, 4'd0);
    @(negedge clk);
    checks++;
    if (b8.o_miso !== 1'b1) begin errors++; $display("FAIL send_msb got=%b exp=1", b8.o_miso); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({b8.o_miso, b8.o_done} !== 2'b00) begin
      errors++; $display("FAIL async_reset got=%b exp=00", {b8.o_miso, b8.o_done});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (b8.o_done || b8.o_miso || b8.o_abort) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] got, e;
    int early, junk, w, sel;
    logic de, da;
    logic [31:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < 12; i++) begin
      sel = (i % 4 == 3) ? 1 : 0;
      w   = (sel == 1) ? 16 : 8;
      a   = $urandom & ((32'd1 << w) - 32'd1);
      b   = $urandom & ((32'd1 << w) - 32'd1);
      op  = (i < 8) ? i[3:0] : 4'($urandom_range(0, 15));
      exp_q.push_back(model(w, a, b, op));
      do_frame(sel, w, a, b, op, 0, got, early, de, da, junk);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || de !== 1'b1 || early != 0) begin
        errors++;
        $display("FAIL b2b%0d w=%0d a=%h b=%h op=%0d got=%h exp=%h done=%b early=%0d",
                 i, w, a, b, op, got, e, de, early);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_vectors();
    test_abort();
    test_reset_mid_send();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
